// File: rtl/y86_pkg.sv
// y86_pkg: shared constants for the Y86-64 pipeline control slice.
//   - icode constants for the instructions the control unit reacts to
//   - RNONE register ID meaning "no register"
//   - status codes carried down the pipe with each instruction
//   - run-state encoding of the control FSM (also the 'state' output)
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [1:0] SAOK = 2'd0;
  localparam logic [1:0] SHLT = 2'd1;
  localparam logic [1:0] SADR = 2'd2;
  localparam logic [1:0] SINS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_STOPPED = 2'd3
  } run_state_t;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: purely combinational hazard classification.
// Inputs : D/E/M stage icodes, decode source registers, execute-stage
//          memory destination, branch condition, M and W status.
// Outputs: loaduse - E stage loads a register that decode is reading
//          mispred - E stage holds a not-taken conditional jump
//          retp    - a ret is somewhere in D, E or M
//          exc_m   - M stage carries a non-AOK status
//          exc_w   - W stage carries a non-AOK status
module hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] E_icode,
  input  logic [3:0] M_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [1:0] m_stat,
  input  logic [1:0] W_stat,
  output logic       loaduse,
  output logic       mispred,
  output logic       retp,
  output logic       exc_m,
  output logic       exc_w
);

  logic eIsLoad;

  assign eIsLoad = (E_icode == IMRMOVQ) || (E_icode == IPOPQ);

  // RNONE on E_dstM must never match a decode source of RNONE.
  assign loaduse = eIsLoad && (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));

  // The pipeline predicts taken, so a false condition is a mispredict.
  assign mispred = (E_icode == IJXX) && !e_Cnd;

  assign retp  = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
  assign exc_m = (m_stat != SAOK);
  assign exc_w = (W_stat != SAOK);

endmodule

// File: rtl/y86_pipe_ctrl.sv
// y86_pipe_ctrl: pipeline control unit for the five-stage Y86-64 core.
// Inputs : clk, rst (async active-low), start/step pulses, step_mode level,
//          stage icodes, decode sources, E_dstM, e_Cnd, m_stat, W_stat.
// Outputs: F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
//          set_cc, run state, latched exception code, and the cycle,
//          retire and stall counters.
//
// start and step are single-cycle pulses sampled on the rising edge; they
// take effect only in IDLE and PAUSE respectively and are otherwise
// ignored. There is no back-pressure: the pipe registers sample the
// controls on the same edge they are produced for.
module y86_pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic [1:0]       state,
  output logic [1:0]       exc_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  run_state_t runState, nextState;
  logic loadUse, mispred, retP, excM, excW;
  logic fStallRun;

  hazard_detect uHazard (
    .D_icode (D_icode),
    .E_icode (E_icode),
    .M_icode (M_icode),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .E_dstM  (E_dstM),
    .e_Cnd   (e_Cnd),
    .m_stat  (m_stat),
    .W_stat  (W_stat),
    .loaduse (loadUse),
    .mispred (mispred),
    .retp    (retP),
    .exc_m   (excM),
    .exc_w   (excW)
  );

  // Fetch stall as it would be in RUN; also decides whether a fetch
  // happened this cycle for single-step pausing.
  assign fStallRun = loadUse || retP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      runState <= ST_IDLE;
      exc_code <= SAOK;
    end else begin
      runState <= nextState;
      if (runState == ST_RUN && excW) exc_code <= W_stat;
    end
  end

  always_comb begin
    nextState = runState;
    F_stall   = 1'b0;
    D_stall   = 1'b0;
    D_bubble  = 1'b0;
    E_bubble  = 1'b0;
    M_bubble  = 1'b0;
    W_stall   = 1'b0;
    set_cc    = 1'b0;
    unique case (runState)
      ST_IDLE: begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        if (start) nextState = ST_RUN;
      end
      ST_RUN: begin
        F_stall  = fStallRun;
        D_stall  = loadUse;
        // A load-use stall must hold D, so it overrides the ret bubble.
        D_bubble = mispred || (retP && !loadUse);
        E_bubble = mispred || loadUse;
        M_bubble = excM || excW;
        W_stall  = excW;
        // No CC update once a faulting instruction is further down the pipe.
        set_cc   = (E_icode == IOPQ) && !excM && !excW;
        if (excW)                        nextState = ST_STOPPED;
        else if (step_mode && !fStallRun) nextState = ST_PAUSE;
      end
      ST_PAUSE: begin
        F_stall = 1'b1;
        D_stall = 1'b1;
        W_stall = 1'b1;
        if (step || !step_mode) nextState = ST_RUN;
      end
      ST_STOPPED: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        W_stall  = 1'b1;
        M_bubble = 1'b1;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else if (runState == ST_RUN) begin
      cycle_cnt <= cycle_cnt + CNT_ONE;
      // Bubbles travel as nops, so a nop in W is not a retirement.
      if (W_stat == SAOK && W_icode != INOP) retire_cnt <= retire_cnt + CNT_ONE;
      if (fStallRun) stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign state = runState;

endmodule
